// File: rtl/div_if.sv
// Divider request/response bundle between the EX stage (master) and the
// multi-cycle divider (slave).
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result packs {remainder, quotient}; ready stays high while start is held,
// so the EX stall releases only once the stage has seen the result.
module div #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [2*DATA_W:0]   dividend, dividend_nxt;
  logic [DATA_W-1:0]   divisor, divisor_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2*DATA_W-1:0] result, result_nxt;
  logic                ready, ready_nxt;
  logic [DATA_W:0]     div_temp;

  // Two's-complement negate when cond is set, pass through otherwise.
  function automatic logic [DATA_W-1:0] neg_if(input logic cond, input logic [DATA_W-1:0] v);
    neg_if = cond ? (~v + ONE_W) : v;
  endfunction

  // Magnitude of an operand; only signed operations with MSB set are negated.
  function automatic logic [DATA_W-1:0] abs_val(input logic sgn, input logic [DATA_W-1:0] v);
    abs_val = neg_if(sgn & v[DATA_W-1], v);
  endfunction

  // Trial subtraction of the divisor from the upper partial remainder.
  always_comb begin
    div_temp = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  end

  // Next-state and datapath updates for the division FSM.
  always_comb begin
    state_nxt    = state;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    cnt_nxt      = cnt;
    result_nxt   = result;
    ready_nxt    = ready;
    case (state)
      DIV_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = {(2*DATA_W){1'b0}};
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == {DATA_W{1'b0}}) begin
            state_nxt = DIV_BY_ZERO;
          end else begin
            divisor_nxt  = abs_val(bus.signed_div_i, bus.opdata2_i);
            dividend_nxt = {{DATA_W{1'b0}}, abs_val(bus.signed_div_i, bus.opdata1_i), 1'b0};
            cnt_nxt      = {CNT_W{1'b0}};
            state_nxt    = DIV_ON;
          end
        end else begin
          state_nxt = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        dividend_nxt = {(2*DATA_W+1){1'b0}};
        state_nxt    = DIV_END;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_nxt = DIV_FREE;
          cnt_nxt   = {CNT_W{1'b0}};
        end else if (cnt != CNT_LAST) begin
          if (div_temp[DATA_W]) begin
            dividend_nxt = {dividend[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_nxt = {div_temp[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
          end
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // Sign fix-up re-samples the operands, which EX holds stable.
          dividend_nxt = {
            neg_if(bus.signed_div_i & bus.opdata1_i[DATA_W-1], dividend[2*DATA_W:DATA_W+1]),
            dividend[DATA_W],
            neg_if(bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]),
                   dividend[DATA_W-1:0])
          };
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        result_nxt = {dividend[2*DATA_W:DATA_W+1], dividend[DATA_W-1:0]};
        ready_nxt  = 1'b1;
        if (!bus.start_i) begin
          state_nxt  = DIV_FREE;
          ready_nxt  = 1'b0;
          result_nxt = {(2*DATA_W){1'b0}};
        end else begin
          state_nxt = DIV_END;
        end
      end
      default: begin
        state_nxt  = DIV_FREE;
        cnt_nxt    = {CNT_W{1'b0}};
        ready_nxt  = 1'b0;
        result_nxt = {(2*DATA_W){1'b0}};
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      dividend <= {(2*DATA_W+1){1'b0}};
      divisor  <= {DATA_W{1'b0}};
      cnt      <= {CNT_W{1'b0}};
      result   <= {(2*DATA_W){1'b0}};
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      cnt      <= cnt_nxt;
      result   <= result_nxt;
      ready    <= ready_nxt;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the multi-cycle divider.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) bus ();

  div #(.DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    tick(1);
    rst = 1'b1;
    tick(3);
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL reset_idle: ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  // Runs a table of divisions, checking exact latency, result and release.
  task automatic test_table(input string name, input logic sgn,
                            input logic [31:0] va [4], input logic [31:0] vb [4],
                            input logic [63:0] ve [4]);
    for (int i = 0; i < 4; i++) begin
      start_op(sgn, va[i], vb[i]);
      tick(34);
      tests++;
      if (bus.ready_o !== 1'b0) begin
        fails++;
        $display("FAIL %s_early[%0d]: ready=%b after 33 edges, want 0", name, i, bus.ready_o);
      end
      tick(1);
      tests++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== ve[i]) begin
        fails++;
        $display("FAIL %s_result[%0d]: ready=%b result=%h, want 1/%h", name, i,
                 bus.ready_o, bus.result_o, ve[i]);
      end
      bus.start_i = 1'b0;
      tick(1);
      tests++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
        fails++;
        $display("FAIL %s_release[%0d]: ready=%b result=%h, want 0/0", name, i,
                 bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] va [4] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd9};
    logic [31:0] vb [4] = '{32'd7, 32'd1, 32'd2, 32'd3};
    logic [63:0] ve [4] = '{64'h00000002_0000000E, 64'h00000000_FFFFFFFF,
                            64'h00000001_7FFFFFFC, 64'h00000000_00000003};
    test_table("unsigned", 1'b0, va, vb, ve);
  endtask

  task automatic test_signed();
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF8};
    logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    logic [63:0] ve [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                            64'h00000000_80000000, 64'hFFFFFFFE_FFFFFFFE};
    test_table("signed", 1'b1, va, vb, ve);
  endtask

  task automatic test_div_by_zero();
    start_op(1'b0, 32'h1234_5678, 32'h0);
    tick(2);
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL dbz_early: ready=%b after 1 edge, want 0", bus.ready_o);
    end
    tick(1);
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL dbz_result: ready=%b result=%h, want 1/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    tick(1);
  endtask

  task automatic test_annul();
    logic rose = 1'b0;
    start_op(1'b0, 32'd100, 32'd7);
    tick(11);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick(1);
    rose = bus.ready_o;
    bus.annul_i = 1'b0;
    start_op(1'b0, 32'd9, 32'd3);
    for (int k = 0; k < 34; k++) begin
      if (bus.ready_o === 1'b1) rose = 1'b1;
      tick(1);
    end
    tests++;
    if (rose !== 1'b0) begin
      fails++;
      $display("FAIL annul_early: ready rose=%b before 34 edges, want 0", rose);
    end
    tick(1);
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_00000003) begin
      fails++;
      $display("FAIL annul_restart: ready=%b result=%h, want 1/%h", bus.ready_o,
               bus.result_o, 64'h00000000_00000003);
    end
    bus.start_i = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    start_op(1'b0, 32'd100, 32'd7);
    tick(35);
    bus.annul_i = 1'b1;
    tick(3);
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
      fails++;
      $display("FAIL hold_end: ready=%b result=%h, want 1/%h", bus.ready_o,
               bus.result_o, 64'h00000002_0000000E);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick(1);
    start_op(1'b0, 32'd50, 32'd5);
    tick(35);
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_0000000A) begin
      fails++;
      $display("FAIL b2b_result: ready=%b result=%h, want 1/%h", bus.ready_o,
               bus.result_o, 64'h00000000_0000000A);
    end
    bus.start_i = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset();
    start_op(1'b0, 32'd1000, 32'd3);
    tick(21);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid: ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    tick(1);
    rst = 1'b1;
    start_op(1'b0, 32'd50, 32'd5);
    tick(34);
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart_early: ready=%b after 33 edges, want 0", bus.ready_o);
    end
    tick(1);
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_0000000A) begin
      fails++;
      $display("FAIL rst_restart: ready=%b result=%h, want 1/%h", bus.ready_o,
               bus.result_o, 64'h00000000_0000000A);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL rst_at_end: ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
